// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
//   Shares port 2 (read/write) of the dual-port data RAM between two requesters:
//   requester 0 is the core load/store unit, requester 1 is the debug/program
//   loader. Grants are round-robin. A requester can hold the port for a bounded
//   burst of up to MAX_BURST consecutive accesses by asserting its lock input.
//   The RAM read path is combinational, so an access completes in the cycle in
//   which its ack is high.
//
//   Build option: define ARB_FIXED_PRIORITY_EN to make requester 1 win every
//   tie. The lock/MAX_BURST rule still applies in that build.
//
// Ports
//   clk, reset                    rising-edge clock, synchronous active-high reset
//   reqN, lockN                   access request (held until ackN), burst continuation
//   addrN, wdataN, maskN, weN     access address, write data, byte mask, write enable
//   ackN                          access performed this cycle
//   rdataN                        read data, valid when ackN=1
//   ram_a, ram_di, ram_m, ram_we  RAM port-2 address, write data, byte mask, write enable
//   ram_do                        RAM port-2 read data
//   busy                          arbiter is granting a requester
module ram_port_arbiter #(
  parameter int MAX_BURST = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        lock0,
  input  logic [31:0] addr0,
  input  logic [31:0] wdata0,
  input  logic [3:0]  mask0,
  input  logic        we0,
  output logic        ack0,
  output logic [31:0] rdata0,
  input  logic        req1,
  input  logic        lock1,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata1,
  input  logic [3:0]  mask1,
  input  logic        we1,
  output logic        ack1,
  output logic [31:0] rdata1,
  output logic [31:0] ram_a,
  output logic [31:0] ram_di,
  output logic [3:0]  ram_m,
  output logic        ram_we,
  input  logic [31:0] ram_do,
  output logic        busy
);

  localparam int CNT_W = $clog2(MAX_BURST) + 1;
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic             last, last_nxt;
  logic [CNT_W-1:0] burst_cnt, burst_cnt_nxt;

  logic elig0, elig1;
  logic stay0, stay1;
  logic pick_vld, pick_id;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      last      <= 1'b1;
      burst_cnt <= '0;
    end else begin
      state     <= state_nxt;
      last      <= last_nxt;
      burst_cnt <= burst_cnt_nxt;
    end
  end

  // Next-state decision
  always_comb begin
    state_nxt     = IDLE;
    last_nxt      = last;
    burst_cnt_nxt = '0;
    pick_vld      = 1'b0;
    pick_id       = 1'b0;

    // The requester being served this cycle still holds req during its ack
    // cycle; masking it out stops it from being acked twice for one access.
    elig0 = req0 && (state != GRANT0);
    elig1 = req1 && (state != GRANT1);

    stay0 = (state == GRANT0) && lock0 && req0 && (burst_cnt < BURST_LAST);
    stay1 = (state == GRANT1) && lock1 && req1 && (burst_cnt < BURST_LAST);

    if (elig0 && elig1) begin
      pick_vld = 1'b1;
`ifdef ARB_FIXED_PRIORITY_EN
      pick_id  = 1'b1;
`else
      pick_id  = ~last;
`endif
    end else if (elig0) begin
      pick_vld = 1'b1;
      pick_id  = 1'b0;
    end else if (elig1) begin
      pick_vld = 1'b1;
      pick_id  = 1'b1;
    end

    if (stay0) begin
      state_nxt     = GRANT0;
      last_nxt      = 1'b0;
      burst_cnt_nxt = burst_cnt + 1'b1;
    end else if (stay1) begin
      state_nxt     = GRANT1;
      last_nxt      = 1'b1;
      burst_cnt_nxt = burst_cnt + 1'b1;
    end else if (pick_vld) begin
      // A picked requester is never the one currently granted, so this is
      // always an entry from a different state and the burst count restarts.
      state_nxt     = pick_id ? GRANT1 : GRANT0;
      last_nxt      = pick_id;
      burst_cnt_nxt = '0;
    end
  end

  // Port-2 drive and acks. Gated by reset so a grant cut short by reset
  // cannot write the RAM during the reset cycle.
  always_comb begin
    ram_a  = '0;
    ram_di = '0;
    ram_m  = '0;
    ram_we = 1'b0;
    ack0   = 1'b0;
    ack1   = 1'b0;
    busy   = 1'b0;
    if (!reset) begin
      case (state)
        GRANT0: begin
          ram_a  = addr0;
          ram_di = wdata0;
          ram_m  = mask0;
          ram_we = we0;
          ack0   = 1'b1;
          busy   = 1'b1;
        end
        GRANT1: begin
          ram_a  = addr1;
          ram_di = wdata1;
          ram_m  = mask1;
          ram_we = we1;
          ack1   = 1'b1;
          busy   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign rdata0 = ram_do;
  assign rdata1 = ram_do;

endmodule

// File: tb/tb_ram_port_arbiter.sv
module tb_ram_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, lock0, we0, req1, lock1, we1;
  logic [31:0] addr0, wdata0, addr1, wdata1;
  logic [3:0]  mask0, mask1;
  logic        ack0, ack1;
  logic [31:0] rdata0, rdata1;
  logic [31:0] ram_a, ram_di, ram_do;
  logic [3:0]  ram_m;
  logic        ram_we, busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ram_port_arbiter #(.MAX_BURST(4)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .lock0(lock0), .addr0(addr0), .wdata0(wdata0), .mask0(mask0),
    .we0(we0), .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .lock1(lock1), .addr1(addr1), .wdata1(wdata1), .mask1(mask1),
    .we1(we1), .ack1(ack1), .rdata1(rdata1),
    .ram_a(ram_a), .ram_di(ram_di), .ram_m(ram_m), .ram_we(ram_we),
    .ram_do(ram_do), .busy(busy)
  );

  // Byte-masked RAM with combinational read
  logic [31:0] mem [0:63] = '{default: 32'h0};
  assign ram_do = mem[ram_a[7:2]];
  always @(posedge clk) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++)
        if (ram_m[b]) mem[ram_a[7:2]][8*b +: 8] <= ram_di[8*b +: 8];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req0 = 0; lock0 = 0; addr0 = 0; wdata0 = 0; mask0 = 0; we0 = 0;
    req1 = 0; lock1 = 0; addr1 = 0; wdata1 = 0; mask1 = 0; we1 = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // Single access through requester 1; reports ack and read data seen in the
  // cycle after the request is sampled, then releases the request.
  task automatic access1(input logic [31:0] a, input logic w, input logic [31:0] d,
                         input logic [3:0] m, output logic ack, output logic [31:0] rd);
    req1 = 1; addr1 = a; we1 = w; wdata1 = d; mask1 = m; lock1 = 0;
    tick();
    ack = ack1;
    rd  = rdata1;
    tick();
    req1 = 0; we1 = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    tick();
    n_checks++; if (ack0 !== 1'b0) begin n_fail++; $display("FAIL rst_ack0 got=%b exp=0", ack0); end
    n_checks++; if (ack1 !== 1'b0) begin n_fail++; $display("FAIL rst_ack1 got=%b exp=0", ack1); end
    n_checks++; if (ram_we !== 1'b0) begin n_fail++; $display("FAIL rst_ram_we got=%b exp=0", ram_we); end
    n_checks++; if (ram_a !== 32'h0 || ram_di !== 32'h0 || ram_m !== 4'h0)
      begin n_fail++; $display("FAIL rst_ram_bus got a=%h di=%h m=%h exp all 0", ram_a, ram_di, ram_m); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%b exp=0", busy); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_write();
    req0 = 1; addr0 = 32'h10; we0 = 1; wdata0 = 32'hA5A5A5A5; mask0 = 4'hF;
    n_checks++; if (ack0 !== 1'b0) begin n_fail++; $display("FAIL wr_ack_early got=%b exp=0", ack0); end
    tick();
    n_checks++; if (ack0 !== 1'b1) begin n_fail++; $display("FAIL wr_ack0 got=%b exp=1", ack0); end
    n_checks++; if (ram_we !== 1'b1) begin n_fail++; $display("FAIL wr_ram_we got=%b exp=1", ram_we); end
    n_checks++; if (ram_a !== 32'h10) begin n_fail++; $display("FAIL wr_ram_a got=%h exp=00000010", ram_a); end
    n_checks++; if (ram_di !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL wr_ram_di got=%h exp=a5a5a5a5", ram_di); end
    tick();
    n_checks++; if (ack0 !== 1'b0) begin n_fail++; $display("FAIL wr_no_double_ack got=%b exp=0", ack0); end
    we0 = 0; wdata0 = 0;
    tick();
    n_checks++; if (ack0 !== 1'b1) begin n_fail++; $display("FAIL rd_ack0 got=%b exp=1", ack0); end
    n_checks++; if (rdata0 !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL rd_rdata0 got=%h exp=a5a5a5a5", rdata0); end
    tick();
    req0 = 0;
    tick();
  endtask

  task automatic test_alternate();
    logic first;
`ifdef ARB_FIXED_PRIORITY_EN
    first = 1'b1;
`else
    first = 1'b0;
`endif
    do_reset();
    req0 = 1; addr0 = 32'h10; req1 = 1; addr1 = 32'h20;
    for (int i = 0; i < 6; i++) begin
      logic exp1;
      tick();
      exp1 = first ^ i[0];
      n_checks++;
      if (ack0 !== ~exp1 || ack1 !== exp1 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL alt_cycle%0d got ack0=%b ack1=%b busy=%b exp ack0=%b ack1=%b busy=1",
                 i, ack0, ack1, busy, ~exp1, exp1);
      end
    end
    tick();
    req0 = 0; req1 = 0;
    tick();
    tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL alt_idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_burst_lock();
    logic [5:0] exp_ack1;
    do_reset();
    req1 = 1; lock1 = 1; addr1 = 32'h20;
    tick();
    req0 = 1; addr0 = 32'h10;
    n_checks++; if (ack1 !== 1'b1) begin n_fail++; $display("FAIL burst_first_ack1 got=%b exp=1", ack1); end
    for (int i = 2; i <= 4; i++) begin
      tick();
      n_checks++;
      if (ack1 !== 1'b1 || ack0 !== 1'b0) begin
        n_fail++; $display("FAIL burst_ack%0d got ack1=%b ack0=%b exp ack1=1 ack0=0", i, ack1, ack0);
      end
    end
    tick();
    n_checks++;
    if (ack0 !== 1'b1 || ack1 !== 1'b0) begin
      n_fail++; $display("FAIL burst_handover got ack0=%b ack1=%b exp ack0=1 ack1=0", ack0, ack1);
    end
    req1 = 0; lock1 = 0;
    tick();
    n_checks++; if (ack0 !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL burst_end got ack0=%b busy=%b exp 0 0", ack0, busy); end
    req0 = 0;
    tick();
    // Locked lone requester: four acks, forced out for one decision, then back
    exp_ack1 = 6'b101111;
    req1 = 1; lock1 = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_checks++;
      if (ack1 !== exp_ack1[i]) begin
        n_fail++; $display("FAIL lock_alone_cycle%0d got ack1=%b exp=%b", i, ack1, exp_ack1[i]);
      end
    end
    req1 = 0; lock1 = 0;
    tick();
    tick();
  endtask

  task automatic test_lone_bubble();
    logic [5:0] exp_pat;
    exp_pat = 6'b101010;
    req0 = 1; addr0 = 32'h10; we0 = 0;
    for (int i = 0; i < 6; i++) begin
      if (i != 0) tick();
      n_checks++;
      if (ack0 !== exp_pat[i] || busy !== exp_pat[i]) begin
        n_fail++; $display("FAIL bubble_cycle%0d got ack0=%b busy=%b exp=%b", i, ack0, busy, exp_pat[i]);
      end
    end
    tick();
    req0 = 0;
    tick();
  endtask

  task automatic test_byte_mask();
    logic        a;
    logic [31:0] rd;
    access1(32'h20, 1'b1, 32'h11223344, 4'hF, a, rd);
    n_checks++; if (a !== 1'b1) begin n_fail++; $display("FAIL mask_init_ack got=%b exp=1", a); end
    access1(32'h20, 1'b1, 32'h0000BB00, 4'h2, a, rd);
    n_checks++; if (a !== 1'b1) begin n_fail++; $display("FAIL mask_wr_ack got=%b exp=1", a); end
    access1(32'h20, 1'b0, 32'h0, 4'h0, a, rd);
    n_checks++; if (rd !== 32'h1122BB44) begin n_fail++; $display("FAIL mask_readback got=%h exp=1122bb44", rd); end
  endtask

  task automatic test_reset_mid_grant();
    logic        a;
    logic [31:0] rd;
    access1(32'h30, 1'b1, 32'h12345678, 4'hF, a, rd);
    req1 = 1; addr1 = 32'h30; we1 = 1; wdata1 = 32'hDEADBEEF; mask1 = 4'hF;
    tick();
    n_checks++; if (ack1 !== 1'b1) begin n_fail++; $display("FAIL rstmid_grant got ack1=%b exp=1", ack1); end
    reset = 1'b1;
    #1;
    n_checks++; if (ram_we !== 1'b0) begin n_fail++; $display("FAIL rstmid_ram_we got=%b exp=0", ram_we); end
    n_checks++; if (ack1 !== 1'b0) begin n_fail++; $display("FAIL rstmid_ack1 got=%b exp=0", ack1); end
    tick();
    reset = 1'b0; req1 = 0; we1 = 0;
    #1;
    n_checks++; if (busy !== 1'b0 || ack1 !== 1'b0) begin n_fail++; $display("FAIL rstmid_idle got busy=%b ack1=%b exp 0 0", busy, ack1); end
    tick();
    access1(32'h30, 1'b0, 32'h0, 4'h0, a, rd);
    n_checks++; if (rd !== 32'h12345678) begin n_fail++; $display("FAIL rstmid_word got=%h exp=12345678", rd); end
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    test_reset();
    test_single_write();
    test_alternate();
    test_burst_lock();
    test_lone_bubble();
    test_byte_mask();
    test_reset_mid_grant();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
